tec_datapath: RTL and testbench

- Execution datapath and beat sequencer that consumes the hardwired controller's control word: SEL, S, M, CIN, DRW, bus enables, PC/AR/IR loads, MEMW, LDC/LDZ.
- Returns the controller's inputs: beat vector W[3:1], the IR high nibble, and flags C and Z.
- Contains four 8-bit general registers, a 74181-compatible ALU, PC, AR, IR, an internal RAM, a single shared data bus, and a halt/start latch driven by STOP and the QD button.

---
 rtl/tec_datapath_if.sv | 41 ++++
 rtl/tec_datapath.sv | 170 +++++++++++++++++
 tb/tb_tec_datapath.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tec_datapath_if.sv
// Control word from the hardwired controller into the datapath, plus the
// beat/opcode/flag status the controller reads back.
interface tec_datapath_if;
  logic [3:0] SEL;
  logic       SELCTL;
  logic [3:0] S;
  logic       M;
  logic       CIN;
  logic       ABUS;
  logic       SBUS;
  logic       MBUS;
  logic       DRW;
  logic       LPC;
  logic       PCINC;
  logic       PCADD;
  logic       LAR;
  logic       ARINC;
  logic       LIR;
  logic       MEMW;
  logic       LDC;
  logic       LDZ;
  logic       SHORT;
  logic       LONG;
  logic       STOP;
  logic [2:0] W;
  logic [3:0] IR_HI;
  logic       C;
  logic       Z;

  modport master (
    output SEL, SELCTL, S, M, CIN, ABUS, SBUS, MBUS, DRW, LPC, PCINC, PCADD,
           LAR, ARINC, LIR, MEMW, LDC, LDZ, SHORT, LONG, STOP,
    input  W, IR_HI, C, Z
  );

  modport slave (
    input  SEL, SELCTL, S, M, CIN, ABUS, SBUS, MBUS, DRW, LPC, PCINC, PCADD,
           LAR, ARINC, LIR, MEMW, LDC, LDZ, SHORT, LONG, STOP,
    output W, IR_HI, C, Z
  );
endinterface

// File: rtl/tec_datapath.sv
// Execution datapath and W1/W2/W3 beat sequencer for the hardwired controller.
// All state changes on the falling edge of T3; CLR is an async active-low reset.
module tec_datapath #(
  parameter int DW        = 8,
  parameter int AW        = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic          T3,
  input  logic          CLR,
  input  logic          QD,
  input  logic [DW-1:0] SWD,
  tec_datapath_if.slave ctl,
  output logic [AW-1:0] PC_OUT,
  output logic [AW-1:0] AR_OUT,
  output logic [DW-1:0] BUS_OUT,
  output logic          HALTED,
  output logic          BUS_ERR
);

  typedef enum logic [2:0] {
    BEAT_W1 = 3'b001,
    BEAT_W2 = 3'b010,
    BEAT_W3 = 3'b100
  } beat_t;

  beat_t         r_beat;
  beat_t         w_beat_next;
  logic          r_halted;
  logic          w_halted_next;
  logic          w_act;

  logic [DW-1:0] r_gpr [4];
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_ar;
  logic [DW-1:0] r_ir;
  logic          r_c;
  logic          r_z;
  logic [DW-1:0] r_mem [MEM_DEPTH];

  logic [3:0]    w_sel;
  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  logic [DW-1:0] w_x;
  logic [DW-1:0] w_y;
  logic [DW:0]   w_sum;
  logic [DW-1:0] w_logic;
  logic [DW-1:0] w_f;
  logic          w_cout;
  logic [DW-1:0] w_bus;
  logic [AW-1:0] w_ofs;

  assign w_act = ~r_halted;
  assign w_sel = ctl.SELCTL ? ctl.SEL : r_ir[3:0];
  assign w_a   = r_gpr[w_sel[3:2]];
  assign w_b   = r_gpr[w_sel[1:0]];

  // 74181 arithmetic: F = (A | B&S0 | ~B&S1) + (A&~B&S2 | A&B&S3) + carry, Cn low means carry in.
  assign w_x   = w_a | (w_b & {DW{ctl.S[0]}}) | (~w_b & {DW{ctl.S[1]}});
  assign w_y   = (w_a & ~w_b & {DW{ctl.S[2]}}) | (w_a & w_b & {DW{ctl.S[3]}});
  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{DW{1'b0}}, ~ctl.CIN};

  // 74181 logic-mode function table
  always_comb begin
    w_logic = {DW{1'b0}};
    case (ctl.S)
      4'b0000: w_logic = ~w_a;
      4'b0001: w_logic = ~(w_a | w_b);
      4'b0010: w_logic = ~w_a & w_b;
      4'b0011: w_logic = {DW{1'b0}};
      4'b0100: w_logic = ~(w_a & w_b);
      4'b0101: w_logic = ~w_b;
      4'b0110: w_logic = w_a ^ w_b;
      4'b0111: w_logic = w_a & ~w_b;
      4'b1000: w_logic = ~w_a | w_b;
      4'b1001: w_logic = ~(w_a ^ w_b);
      4'b1010: w_logic = w_b;
      4'b1011: w_logic = w_a & w_b;
      4'b1100: w_logic = {DW{1'b1}};
      4'b1101: w_logic = w_a | ~w_b;
      4'b1110: w_logic = w_a | w_b;
      default: w_logic = w_a;
    endcase
  end

  assign w_f    = ctl.M ? w_logic : w_sum[DW-1:0];
  assign w_cout = ctl.M ? 1'b0 : w_sum[DW];

  // Wired-OR bus: overlapping drivers still merge, BUS_ERR just flags the conflict.
  assign w_bus   = ({DW{ctl.ABUS}} & w_f) | ({DW{ctl.SBUS}} & SWD) |
                   ({DW{ctl.MBUS}} & r_mem[r_ar]);
  assign BUS_ERR = (ctl.ABUS & ctl.SBUS) | (ctl.ABUS & ctl.MBUS) | (ctl.SBUS & ctl.MBUS);
  assign w_ofs   = {{(AW-4){r_ir[3]}}, r_ir[3:0]};

  // Beat/halt next state; a QD release edge only clears the halt and runs nothing.
  always_comb begin
    w_beat_next   = r_beat;
    w_halted_next = r_halted;
    if (r_halted) begin
      if (QD) begin
        w_halted_next = 1'b0;
      end else begin
        w_halted_next = 1'b1;
      end
    end else begin
      case (r_beat)
        BEAT_W1: w_beat_next = ctl.SHORT ? BEAT_W1 : BEAT_W2;
        BEAT_W2: w_beat_next = ctl.LONG ? BEAT_W3 : BEAT_W1;
        BEAT_W3: w_beat_next = BEAT_W1;
        default: w_beat_next = BEAT_W1;
      endcase
      if (ctl.STOP) begin
        w_halted_next = 1'b1;
      end else begin
        w_halted_next = 1'b0;
      end
    end
  end

  // Sequencer state register
  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      r_beat   <= BEAT_W1;
      r_halted <= 1'b1;
    end else begin
      r_beat   <= w_beat_next;
      r_halted <= w_halted_next;
    end
  end

  // Register file, PC, AR, IR and flags; every source is a pre-edge value.
  always_ff @(negedge T3 or negedge CLR) begin
    if (!CLR) begin
      for (int i = 0; i < 4; i++) begin
        r_gpr[i] <= {DW{1'b0}};
      end
      r_pc <= {AW{1'b0}};
      r_ar <= {AW{1'b0}};
      r_ir <= {DW{1'b0}};
      r_c  <= 1'b0;
      r_z  <= 1'b0;
    end else if (w_act) begin
      if (ctl.DRW)   r_gpr[w_sel[3:2]] <= w_bus;
      if (ctl.LDC)   r_c <= w_cout;
      if (ctl.LDZ)   r_z <= (w_f == {DW{1'b0}});
      if (ctl.LIR)   r_ir <= r_mem[r_pc];
      if (ctl.LPC)        r_pc <= w_bus[AW-1:0];
      else if (ctl.PCADD) r_pc <= r_pc + w_ofs;
      else if (ctl.PCINC) r_pc <= r_pc + {{(AW-1){1'b0}}, 1'b1};
      if (ctl.LAR)        r_ar <= w_bus[AW-1:0];
      else if (ctl.ARINC) r_ar <= r_ar + {{(AW-1){1'b0}}, 1'b1};
    end
  end

  // RAM is deliberately left out of reset
  always_ff @(negedge T3) begin
    if (w_act && ctl.MEMW) begin
      r_mem[r_ar] <= w_bus;
    end
  end

  assign ctl.W     = r_beat;
  assign ctl.IR_HI = r_ir[DW-1 -: 4];
  assign ctl.C     = r_c;
  assign ctl.Z     = r_z;
  assign PC_OUT    = r_pc;
  assign AR_OUT    = r_ar;
  assign BUS_OUT   = w_bus;
  assign HALTED    = r_halted;

endmodule

// File: tb/tb_tec_datapath.sv
// Self-checking bench for tec_datapath: directed scenarios plus randomized ALU
// traffic, all against a spec-level model that steps once per T3 falling edge.
module tb_tec_datapath;
  logic       T3 = 1'b1;
  logic       CLR;
  logic       QD;
  logic [7:0] SWD;
  logic [7:0] PC_OUT, AR_OUT, BUS_OUT;
  logic       HALTED, BUS_ERR;

  tec_datapath_if ctl();

  tec_datapath #(.DW(8), .AW(8), .MEM_DEPTH(256)) dut (
    .T3(T3), .CLR(CLR), .QD(QD), .SWD(SWD), .ctl(ctl),
    .PC_OUT(PC_OUT), .AR_OUT(AR_OUT), .BUS_OUT(BUS_OUT),
    .HALTED(HALTED), .BUS_ERR(BUS_ERR)
  );

  always #5 T3 = ~T3;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [7:0] m_r [4];
  logic [7:0] m_pc, m_ar, m_ir;
  logic       m_c, m_z, m_halted;
  int         m_w;
  logic [7:0] m_mem [256];

  function automatic logic [2:0] wvec(input int w);
    if (w == 1) return 3'b001;
    else if (w == 2) return 3'b010;
    else return 3'b100;
  endfunction

  // returns {carry_out, result} for the opcodes the controller relies on
  function automatic logic [8:0] alu_ref(input logic m, input logic [3:0] s, input logic cin,
                                         input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    r = 9'h000;
    if (!m) begin
      case (s)
        4'b1001: r = {1'b0, a} + {1'b0, b} + {8'h00, ~cin};
        4'b0110: r = {1'b0, a} + {1'b0, ~b} + {8'h00, ~cin};
        4'b0000: r = {1'b0, a} + {8'h00, ~cin};
        default: r = 9'h000;
      endcase
    end else begin
      case (s)
        4'b1011: r = {1'b0, a & b};
        4'b1110: r = {1'b0, a | b};
        4'b1010: r = {1'b0, b};
        4'b1111: r = {1'b0, a};
        default: r = 9'h000;
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_pc = 8'h00; m_ar = 8'h00; m_ir = 8'h00;
    m_c = 1'b0; m_z = 1'b0; m_w = 1; m_halted = 1'b1;
  endtask

  task automatic model_edge();
    logic [3:0] sel;
    logic [8:0] res;
    logic [7:0] bus, pc0, ar0, ir0;
    if (m_halted) begin
      if (QD) m_halted = 1'b0;
      return;
    end
    pc0 = m_pc; ar0 = m_ar; ir0 = m_ir;
    sel = ctl.SELCTL ? ctl.SEL : ir0[3:0];
    res = alu_ref(ctl.M, ctl.S, ctl.CIN, m_r[sel[3:2]], m_r[sel[1:0]]);
    bus = 8'h00;
    if (ctl.ABUS) bus = bus | res[7:0];
    if (ctl.SBUS) bus = bus | SWD;
    if (ctl.MBUS) bus = bus | m_mem[ar0];
    if (ctl.DRW) m_r[sel[3:2]] = bus;
    if (ctl.LDC) m_c = ctl.M ? 1'b0 : res[8];
    if (ctl.LDZ) m_z = (res[7:0] == 8'h00);
    if (ctl.LIR) m_ir = m_mem[pc0];
    if (ctl.LPC) m_pc = bus;
    else if (ctl.PCADD) m_pc = pc0 + {{4{ir0[3]}}, ir0[3:0]};
    else if (ctl.PCINC) m_pc = pc0 + 8'h01;
    if (ctl.LAR) m_ar = bus;
    else if (ctl.ARINC) m_ar = ar0 + 8'h01;
    if (ctl.MEMW) m_mem[ar0] = bus;
    if (m_w == 1) m_w = ctl.SHORT ? 1 : 2;
    else if (m_w == 2) m_w = ctl.LONG ? 3 : 1;
    else m_w = 1;
    if (ctl.STOP) m_halted = 1'b1;
  endtask

  task automatic clear_ctl();
    ctl.SEL = 4'h0; ctl.SELCTL = 1'b0; ctl.S = 4'h0; ctl.M = 1'b0; ctl.CIN = 1'b0;
    ctl.ABUS = 1'b0; ctl.SBUS = 1'b0; ctl.MBUS = 1'b0; ctl.DRW = 1'b0;
    ctl.LPC = 1'b0; ctl.PCINC = 1'b0; ctl.PCADD = 1'b0; ctl.LAR = 1'b0; ctl.ARINC = 1'b0;
    ctl.LIR = 1'b0; ctl.MEMW = 1'b0; ctl.LDC = 1'b0; ctl.LDZ = 1'b0;
    ctl.SHORT = 1'b0; ctl.LONG = 1'b0; ctl.STOP = 1'b0;
    QD = 1'b0; SWD = 8'h00;
  endtask

  // one T3 falling edge; returns half a period later, away from the edge
  task automatic tick();
    model_edge();
    @(negedge T3);
    @(posedge T3);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] i, input logic [7:0] v);
    clear_ctl();
    ctl.SELCTL = 1'b1; ctl.SEL = {i, 2'b00}; ctl.SBUS = 1'b1; ctl.DRW = 1'b1;
    ctl.SHORT = 1'b1; SWD = v;
    tick();
    clear_ctl();
  endtask

  // combinational peek: put R[i] on the bus through the ALU "A" function
  task automatic read_reg(input logic [1:0] i, output logic [7:0] v);
    clear_ctl();
    ctl.SELCTL = 1'b1; ctl.SEL = {i, 2'b00}; ctl.M = 1'b1; ctl.S = 4'b1111; ctl.ABUS = 1'b1;
    #1;
    v = BUS_OUT;
    clear_ctl();
  endtask

  task automatic goto_w1();
    clear_ctl();
    for (int k = 0; k < 2; k++) if (m_w != 1) tick();
  endtask

  task automatic test_reset();
    logic [7:0] v;
    clear_ctl(); CLR = 1'b0;
    #12; CLR = 1'b1;
    @(posedge T3); #1;
    model_reset();
    checks++; if (HALTED !== 1'b1) begin failures++; $display("FAIL reset_halted got=%0h exp=1", HALTED); end
    checks++; if (ctl.W !== 3'b001) begin failures++; $display("FAIL reset_w got=%b exp=001", ctl.W); end
    checks++; if ({PC_OUT, AR_OUT, ctl.IR_HI, ctl.C, ctl.Z} !== 22'h0) begin failures++; $display("FAIL reset_state pc=%h ar=%h irhi=%h c=%b z=%b exp=all zero", PC_OUT, AR_OUT, ctl.IR_HI, ctl.C, ctl.Z); end
    for (int i = 0; i < 4; i++) begin
      read_reg(i[1:0], v);
      checks++; if (v !== 8'h00) begin failures++; $display("FAIL reset_r%0d got=%h exp=00", i, v); end
    end
    QD = 1'b1; tick(); clear_ctl();
    write_reg(2'd1, 8'h55);
    tick();
    checks++; if (ctl.W !== 3'b010) begin failures++; $display("FAIL pre_clr_w got=%b exp=010", ctl.W); end
    CLR = 1'b0; #2;
    model_reset();
    read_reg(2'd1, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL clr_r1 got=%h exp=00", v); end
    checks++; if ({HALTED, ctl.W, PC_OUT} !== {1'b1, 3'b001, 8'h00}) begin failures++; $display("FAIL clr_state halted=%b w=%b pc=%h exp=1 001 00", HALTED, ctl.W, PC_OUT); end
    CLR = 1'b1;
    @(posedge T3); #1;
    clear_ctl();
    QD = 1'b1; ctl.SELCTL = 1'b1; ctl.SBUS = 1'b1; ctl.DRW = 1'b1; SWD = 8'hEE;
    tick(); clear_ctl();
    read_reg(2'd0, v);
    checks++; if ({HALTED, ctl.W} !== 4'b0001) begin failures++; $display("FAIL qd_release halted=%b w=%b exp=0 001", HALTED, ctl.W); end
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL qd_edge_no_action r0=%h exp=00", v); end
  endtask

  task automatic test_console_write();
    logic [7:0] v;
    clear_ctl();
    ctl.SELCTL = 1'b1; ctl.SEL = 4'b0100; ctl.SBUS = 1'b1; ctl.DRW = 1'b1; SWD = 8'h3C;
    #1;
    checks++; if (BUS_OUT !== 8'h3C) begin failures++; $display("FAIL console_bus got=%h exp=3c", BUS_OUT); end
    checks++; if (BUS_ERR !== 1'b0) begin failures++; $display("FAIL console_buserr got=%b exp=0", BUS_ERR); end
    tick();
    read_reg(2'd1, v);
    checks++; if (v !== 8'h3C) begin failures++; $display("FAIL console_r1 got=%h exp=3c", v); end
  endtask

  task automatic test_add_flags();
    logic [7:0] v;
    write_reg(2'd0, 8'hF0);
    write_reg(2'd1, 8'h20);
    clear_ctl(); ctl.SBUS = 1'b1; ctl.LAR = 1'b1; SWD = m_pc; tick();
    clear_ctl(); ctl.SBUS = 1'b1; ctl.MEMW = 1'b1; SWD = 8'h11; tick();
    clear_ctl(); ctl.LIR = 1'b1; tick();
    checks++; if (ctl.IR_HI !== 4'h1) begin failures++; $display("FAIL lir_irhi got=%h exp=1", ctl.IR_HI); end
    clear_ctl(); ctl.S = 4'b1001; ctl.CIN = 1'b1;
    ctl.ABUS = 1'b1; ctl.DRW = 1'b1; ctl.LDC = 1'b1; ctl.LDZ = 1'b1;
    tick();
    read_reg(2'd0, v);
    checks++; if (v !== 8'h10) begin failures++; $display("FAIL add_r0 got=%h exp=10", v); end
    checks++; if ({ctl.C, ctl.Z} !== 2'b10) begin failures++; $display("FAIL add_flags cz=%b%b exp=10", ctl.C, ctl.Z); end
    clear_ctl(); ctl.SELCTL = 1'b1; ctl.SEL = 4'b0000; ctl.S = 4'b0110; ctl.CIN = 1'b0;
    ctl.ABUS = 1'b1; ctl.DRW = 1'b1; ctl.LDC = 1'b1; ctl.LDZ = 1'b1;
    tick();
    read_reg(2'd0, v);
    checks++; if (v !== 8'h00) begin failures++; $display("FAIL sub_r0 got=%h exp=00", v); end
    checks++; if ({ctl.C, ctl.Z} !== 2'b11) begin failures++; $display("FAIL sub_flags cz=%b%b exp=11", ctl.C, ctl.Z); end
  endtask

  task automatic test_fetch_branch();
    clear_ctl(); ctl.SBUS = 1'b1; ctl.LPC = 1'b1; ctl.LAR = 1'b1; SWD = 8'h00; tick();
    clear_ctl(); ctl.SBUS = 1'b1; ctl.MEMW = 1'b1; SWD = 8'h7E; tick();
    goto_w1();
    clear_ctl(); ctl.LIR = 1'b1; ctl.PCINC = 1'b1; tick();
    checks++; if ({ctl.IR_HI, PC_OUT} !== {4'h7, 8'h01}) begin failures++; $display("FAIL fetch irhi=%h pc=%h exp=7 01", ctl.IR_HI, PC_OUT); end
    checks++; if (ctl.W !== 3'b010) begin failures++; $display("FAIL fetch_w got=%b exp=010", ctl.W); end
    clear_ctl(); ctl.PCADD = 1'b1; ctl.PCINC = 1'b1; tick();
    checks++; if (PC_OUT !== 8'hFF) begin failures++; $display("FAIL pcadd got=%h exp=ff", PC_OUT); end
    clear_ctl(); ctl.PCINC = 1'b1; tick();
    checks++; if (PC_OUT !== 8'h00) begin failures++; $display("FAIL pc_wrap got=%h exp=00", PC_OUT); end
  endtask

  task automatic test_memory();
    logic [7:0] v;
    clear_ctl(); ctl.SBUS = 1'b1; ctl.LAR = 1'b1; SWD = 8'hFF; tick();
    checks++; if (AR_OUT !== 8'hFF) begin failures++; $display("FAIL lar got=%h exp=ff", AR_OUT); end
    clear_ctl(); ctl.SBUS = 1'b1; ctl.MEMW = 1'b1; SWD = 8'hA5; tick();
    clear_ctl(); ctl.ARINC = 1'b1; tick();
    checks++; if (AR_OUT !== 8'h00) begin failures++; $display("FAIL ar_wrap got=%h exp=00", AR_OUT); end
    clear_ctl(); ctl.SBUS = 1'b1; ctl.LAR = 1'b1; SWD = 8'hFF; tick();
    clear_ctl(); ctl.MBUS = 1'b1; ctl.DRW = 1'b1; ctl.SELCTL = 1'b1; ctl.SEL = 4'b1000;
    #1;
    checks++; if (BUS_OUT !== 8'hA5) begin failures++; $display("FAIL mbus got=%h exp=a5", BUS_OUT); end
    tick();
    read_reg(2'd2, v);
    checks++; if (v !== 8'hA5) begin failures++; $display("FAIL mem_to_r2 got=%h exp=a5", v); end
  endtask

  task automatic test_sequencing();
    logic [7:0] v;
    goto_w1();
    for (int k = 0; k < 3; k++) begin
      clear_ctl(); ctl.SHORT = 1'b1; tick();
      checks++; if (ctl.W !== 3'b001) begin failures++; $display("FAIL short_hold got=%b exp=001", ctl.W); end
    end
    clear_ctl(); tick();
    clear_ctl(); ctl.LONG = 1'b1; tick();
    checks++; if (ctl.W !== 3'b100) begin failures++; $display("FAIL long_w3 got=%b exp=100", ctl.W); end
    clear_ctl(); tick();
    checks++; if (ctl.W !== 3'b001) begin failures++; $display("FAIL w3_to_w1 got=%b exp=001", ctl.W); end
    clear_ctl(); tick();
    clear_ctl(); ctl.STOP = 1'b1; tick();
    checks++; if ({HALTED, ctl.W} !== 4'b1001) begin failures++; $display("FAIL stop halted=%b w=%b exp=1 001", HALTED, ctl.W); end
    for (int k = 0; k < 5; k++) begin
      clear_ctl();
      ctl.SELCTL = 1'b1; ctl.SEL = 4'($urandom); ctl.SBUS = 1'b1; ctl.DRW = 1'b1;
      ctl.LPC = 1'b1; ctl.LAR = 1'b1; ctl.STOP = 1'($urandom); SWD = 8'($urandom);
      tick();
      checks++; if ({HALTED, ctl.W, PC_OUT, AR_OUT} !== {m_halted, wvec(m_w), m_pc, m_ar}) begin failures++; $display("FAIL halted_hold halted=%b w=%b pc=%h ar=%h exp=%b %b %h %h", HALTED, ctl.W, PC_OUT, AR_OUT, m_halted, wvec(m_w), m_pc, m_ar); end
    end
    clear_ctl(); QD = 1'b1; tick();
    checks++; if ({HALTED, ctl.W} !== 4'b0001) begin failures++; $display("FAIL qd_resume halted=%b w=%b exp=0 001", HALTED, ctl.W); end
    clear_ctl(); QD = 1'b1; tick();
    checks++; if ({HALTED, ctl.W} !== 4'b0010) begin failures++; $display("FAIL qd_running halted=%b w=%b exp=0 010", HALTED, ctl.W); end
    clear_ctl();
    ctl.SELCTL = 1'b1; ctl.SEL = 4'b0000; ctl.M = 1'b1; ctl.S = 4'b1111;
    ctl.ABUS = 1'b1; ctl.SBUS = 1'b1; SWD = 8'h0F;
    #1;
    v = m_r[0] | 8'h0F;
    checks++; if ({BUS_ERR, BUS_OUT} !== {1'b1, v}) begin failures++; $display("FAIL bus_conflict err=%b bus=%h exp=1 %h", BUS_ERR, BUS_OUT, v); end
    clear_ctl();
  endtask

  task automatic test_random_alu();
    logic [7:0] v;
    int op;
    for (int n = 0; n < 30; n++) begin
      for (int j = 0; j < 4; j++) write_reg(j[1:0], 8'($urandom));
      clear_ctl();
      op = $urandom_range(0, 6);
      case (op)
        0: begin ctl.M = 1'b0; ctl.S = 4'b1001; ctl.CIN = 1'b1; end
        1: begin ctl.M = 1'b0; ctl.S = 4'b0110; ctl.CIN = 1'b0; end
        2: begin ctl.M = 1'b0; ctl.S = 4'b0000; ctl.CIN = 1'b0; end
        3: begin ctl.M = 1'b1; ctl.S = 4'b1011; end
        4: begin ctl.M = 1'b1; ctl.S = 4'b1110; end
        5: begin ctl.M = 1'b1; ctl.S = 4'b1010; end
        default: begin ctl.M = 1'b1; ctl.S = 4'b1111; end
      endcase
      ctl.SELCTL = 1'b1; ctl.SEL = 4'($urandom);
      ctl.ABUS = 1'b1; ctl.DRW = 1'b1; ctl.LDC = 1'b1; ctl.LDZ = 1'b1;
      ctl.SHORT = 1'($urandom); ctl.LONG = 1'($urandom);
      ctl.PCINC = 1'($urandom); ctl.ARINC = 1'($urandom);
      tick();
      for (int j = 0; j < 4; j++) begin
        read_reg(j[1:0], v);
        checks++; if (v !== m_r[j]) begin failures++; $display("FAIL rand_op%0d_r%0d got=%h exp=%h", op, j, v, m_r[j]); end
      end
      checks++; if ({ctl.C, ctl.Z, ctl.W, PC_OUT, AR_OUT} !== {m_c, m_z, wvec(m_w), m_pc, m_ar}) begin failures++; $display("FAIL rand_op%0d_state c=%b z=%b w=%b pc=%h ar=%h exp=%b %b %b %h %h", op, ctl.C, ctl.Z, ctl.W, PC_OUT, AR_OUT, m_c, m_z, wvec(m_w), m_pc, m_ar); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_console_write();
    test_add_flags();
    test_fetch_branch();
    test_memory();
    test_sequencing();
    test_random_alu();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
